// File: rtl/rx_packet_sequencer.sv
// Receive-side packet sequencer: steers the data buffer through sync, PID, payload and CRC checks.
// Optional inter-byte timeout is built only when RX_BYTE_TIMEOUT_EN is defined.
module rx_packet_sequencer #(
    parameter int MAX_DATA_BYTES = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_detect,
    input  logic       byte_complete,
    input  logic       eop,
    input  logic [1:0] sync_status,
    input  logic [2:0] pid_status,
    input  logic [1:0] crc_status,
    output logic       clear,
    output logic       load_sync,
    output logic       check_sync,
    output logic       load_pid,
    output logic       check_pid,
    output logic       load_data,
    output logic       crc_check_5,
    output logic       crc_check_16,
    output logic       load_error,
    output logic       load_done,
    output logic       rx_busy,
    output logic [6:0] byte_count,
    output logic       rx_timeout
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_PID_CHK, ST_TOKEN, ST_CRC5,
        ST_DATA, ST_CRC16, ST_HSHAKE, ST_ERR, ST_EWAIT, ST_DONE
    } state_t;

    localparam logic [31:0] DATA_LIMIT = 32'(MAX_DATA_BYTES + 2);

    state_t      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic        first_sync_q, first_sync_d;
    logic [6:0]  count_inc;
    logic [31:0] count_ext;
    logic        rx_byte;
    logic        collide;
    logic        tmo_hit;
    logic        tmo_pulse;

    assign count_inc = (count_q == 7'h7F) ? count_q : count_q + 7'd1;
    assign count_ext = {25'd0, count_q};
    // A byte that lands together with eop is never a valid byte.
    assign rx_byte   = byte_complete & ~eop;
    assign collide   = byte_complete & eop;

`ifdef RX_BYTE_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmr_q, tmr_d;
    logic       tmo_q;
    logic       tmr_run;

    assign tmr_run   = (state_q != ST_IDLE) && (state_q != ST_EWAIT);
    assign tmo_hit   = tmr_run && !byte_complete && (tmr_q == TMO_LAST);
    assign tmo_pulse = tmo_q;

    always_comb begin
        tmr_d = tmr_q;
        if (state_q == ST_IDLE || byte_complete) begin
            tmr_d = 8'd0;
        end else if (tmr_run) begin
            tmr_d = tmr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            tmo_q <= tmo_hit;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign tmo_pulse = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        first_sync_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_detect) begin
                    state_d      = ST_SYNC;
                    first_sync_d = 1'b1;
                end
            end
            ST_SYNC: begin
                if (eop) begin
                    state_d = ST_ERR;
                end else if (byte_complete) begin
                    state_d = (sync_status == 2'b01) ? ST_PID : ST_ERR;
                end
            end
            ST_PID: begin
                if (eop) begin
                    state_d = ST_ERR;
                end else if (byte_complete) begin
                    state_d = ST_PID_CHK;
                end
            end
            ST_PID_CHK: begin
                case (pid_status)
                    3'b001:  state_d = ST_TOKEN;
                    3'b010:  state_d = ST_DATA;
                    3'b011:  state_d = ST_HSHAKE;
                    default: state_d = ST_ERR;
                endcase
            end
            ST_TOKEN: begin
                if (collide) begin
                    state_d = ST_ERR;
                end else if (rx_byte) begin
                    count_d = count_inc;
                    if (count_q >= 7'd2) begin
                        state_d = ST_ERR;
                    end
                end else if (eop) begin
                    state_d = (count_q == 7'd2) ? ST_CRC5 : ST_ERR;
                end
            end
            ST_CRC5: begin
                state_d = (crc_status == 2'b01) ? ST_DONE : ST_ERR;
            end
            ST_DATA: begin
                if (collide) begin
                    state_d = ST_ERR;
                end else if (rx_byte) begin
                    count_d = count_inc;
                    if (count_ext >= DATA_LIMIT) begin
                        state_d = ST_ERR;
                    end
                end else if (eop) begin
                    state_d = (count_q >= 7'd2) ? ST_CRC16 : ST_ERR;
                end
            end
            ST_CRC16: begin
                state_d = (crc_status == 2'b01) ? ST_DONE : ST_ERR;
            end
            ST_HSHAKE: begin
                if (byte_complete) begin
                    state_d = ST_ERR;
                end else if (eop) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_EWAIT;
            ST_EWAIT: begin
                if (eop) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = ST_IDLE;
        end
        // Keeping the count at zero while idle guarantees a clean start on SYNC entry.
        if (state_d == ST_IDLE) begin
            count_d = 7'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= 7'd0;
            first_sync_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            first_sync_q <= first_sync_d;
        end
    end

    always_comb begin
        clear        = 1'b0;
        load_sync    = 1'b0;
        check_sync   = 1'b0;
        load_pid     = 1'b0;
        check_pid    = 1'b0;
        load_data    = 1'b0;
        crc_check_5  = 1'b0;
        crc_check_16 = 1'b0;
        load_error   = tmo_pulse;
        load_done    = 1'b0;
        case (state_q)
            ST_SYNC: begin
                clear      = first_sync_q;
                load_sync  = 1'b1;
                check_sync = 1'b1;
            end
            ST_PID:     load_pid     = 1'b1;
            ST_PID_CHK: check_pid    = 1'b1;
            ST_DATA:    load_data    = 1'b1;
            ST_CRC5:    crc_check_5  = 1'b1;
            ST_CRC16:   crc_check_16 = 1'b1;
            ST_ERR:     load_error   = 1'b1;
            ST_DONE:    load_done    = 1'b1;
            default: ;
        endcase
    end

    assign rx_busy    = (state_q != ST_IDLE);
    assign byte_count = count_q;
    assign rx_timeout = tmo_pulse;

endmodule

// File: tb/tb_rx_packet_sequencer.sv
// Randomized packet-level bench for rx_packet_sequencer; expected strobe counts come from packet rules.
module tb_rx_packet_sequencer;

    localparam int MAX_DATA_BYTES = 64;
    localparam int TIMEOUT_CYCLES = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_detect = 1'b0;
    logic       byte_complete = 1'b0;
    logic       eop = 1'b0;
    logic [1:0] sync_status = 2'b00;
    logic [2:0] pid_status = 3'b000;
    logic [1:0] crc_status = 2'b00;
    logic       clear, load_sync, check_sync, load_pid, check_pid, load_data;
    logic       crc_check_5, crc_check_16, load_error, load_done, rx_busy, rx_timeout;
    logic [6:0] byte_count;

    always #5 clk = ~clk;

    rx_packet_sequencer #(
        .MAX_DATA_BYTES(MAX_DATA_BYTES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start_detect(start_detect), .byte_complete(byte_complete),
        .eop(eop), .sync_status(sync_status), .pid_status(pid_status), .crc_status(crc_status),
        .clear(clear), .load_sync(load_sync), .check_sync(check_sync), .load_pid(load_pid),
        .check_pid(check_pid), .load_data(load_data), .crc_check_5(crc_check_5),
        .crc_check_16(crc_check_16), .load_error(load_error), .load_done(load_done),
        .rx_busy(rx_busy), .byte_count(byte_count), .rx_timeout(rx_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Running pulse totals; each packet compares the delta across its own span.
    int n_clear = 0, n_pidchk = 0, n_done = 0, n_err = 0;
    int n_crc5 = 0, n_crc16 = 0, n_data = 0, n_tmo = 0;
    int bc_done = 0, bc_err = 0;

    always @(negedge clk) begin
        if (clear)                     n_clear++;
        if (check_pid)                 n_pidchk++;
        if (load_done) begin           n_done++;  bc_done = int'(byte_count); end
        if (load_error) begin          n_err++;   bc_err  = int'(byte_count); end
        if (crc_check_5)               n_crc5++;
        if (crc_check_16)              n_crc16++;
        if (load_data && byte_complete) n_data++;
        if (rx_timeout)                n_tmo++;
    end

    function automatic int out_vec();
        return int'({clear, load_sync, check_sync, load_pid, check_pid, load_data,
                     crc_check_5, crc_check_16, load_error, load_done, rx_busy, rx_timeout});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_byte();
        byte_complete = 1'b1;
        tick();
        byte_complete = 1'b0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    // Inter-byte gap; may inject a stray start_detect, which a busy receiver must ignore.
    task automatic gap(input int lo, input int hi);
        int n;
        n = $urandom_range(hi, lo);
        for (int i = 0; i < n; i++) begin
            if (i == 0 && $urandom_range(3, 0) == 0) start_detect = 1'b1;
            tick();
            start_detect = 1'b0;
        end
    endtask

    // Packet-level rules: what a receiver must report for a given packet shape.
    task automatic model(input logic [2:0] pid, input int nbytes, input bit sync_ok,
                         input bit crc_ok, input bit collide,
                         output int e_pidchk, output int e_done, output int e_err,
                         output int e_crc5, output int e_crc16, output int e_data,
                         output int e_bc, output bit extra_eop);
        int eff;
        eff = collide ? nbytes - 1 : nbytes;
        e_pidchk = 0; e_done = 0; e_err = 0; e_crc5 = 0; e_crc16 = 0;
        e_data = 0; e_bc = 0; extra_eop = 1'b0;
        if (!sync_ok) begin
            e_err = 1;
        end else begin
            e_pidchk = 1;
            case (pid)
                3'b011: begin
                    if (eff >= 1)      e_err = 1;
                    else if (collide) begin e_err = 1; extra_eop = 1'b1; end
                    else               e_done = 1;
                end
                3'b001: begin
                    if (eff >= 3)      e_err = 1;
                    else if (collide || eff != 2) begin e_err = 1; extra_eop = 1'b1; end
                    else begin
                        e_crc5 = 1;
                        if (crc_ok) begin e_done = 1; e_bc = 2; end
                        else begin e_err = 1; extra_eop = 1'b1; end
                    end
                end
                3'b010: begin
                    if (eff > MAX_DATA_BYTES + 2) begin
                        e_err  = 1;
                        e_data = MAX_DATA_BYTES + 3;
                    end else begin
                        e_data = nbytes;
                        e_bc   = eff;
                        if (collide || eff < 2) begin e_err = 1; extra_eop = 1'b1; end
                        else begin
                            e_crc16 = 1;
                            if (crc_ok) e_done = 1;
                            else begin e_err = 1; extra_eop = 1'b1; end
                        end
                    end
                end
                default: e_err = 1;
            endcase
        end
    endtask

    task automatic run_packet(input string name, input logic [2:0] pid, input int nbytes,
                              input bit sync_ok, input bit crc_ok, input bit collide);
        int s_clear, s_pidchk, s_done, s_err, s_crc5, s_crc16, s_data;
        int e_pidchk, e_done, e_err, e_crc5, e_crc16, e_data, e_bc;
        bit extra;
        model(pid, nbytes, sync_ok, crc_ok, collide,
              e_pidchk, e_done, e_err, e_crc5, e_crc16, e_data, e_bc, extra);
        s_clear = n_clear; s_pidchk = n_pidchk; s_done = n_done; s_err = n_err;
        s_crc5 = n_crc5; s_crc16 = n_crc16; s_data = n_data;
        sync_status = sync_ok ? 2'b01 : 2'b10;
        pid_status  = pid;
        crc_status  = crc_ok ? 2'b01 : 2'($urandom_range(3, 2));
        start_detect = 1'b1;
        tick();
        start_detect = 1'b0;
        gap(1, 3);
        pulse_byte();
        gap(1, 3);
        pulse_byte();
        gap(2, 4);
        for (int i = 0; i < nbytes; i++) begin
            if (collide && i == nbytes - 1) begin
                byte_complete = 1'b1;
                eop = 1'b1;
                tick();
                byte_complete = 1'b0;
                eop = 1'b0;
            end else begin
                pulse_byte();
                gap(1, 3);
            end
        end
        if (!collide) pulse_eop();
        idle(4);
        if (extra) pulse_eop();
        idle(3);
        check_val({name, "_clear"},    n_clear - s_clear, 1);
        check_val({name, "_pidchk"},   n_pidchk - s_pidchk, e_pidchk);
        check_val({name, "_done"},     n_done - s_done, e_done);
        check_val({name, "_err"},      n_err - s_err, e_err);
        check_val({name, "_crc5"},     n_crc5 - s_crc5, e_crc5);
        check_val({name, "_crc16"},    n_crc16 - s_crc16, e_crc16);
        check_val({name, "_databyte"}, n_data - s_data, e_data);
        if (e_done == 1) check_val({name, "_bc_done"}, bc_done, e_bc);
        if (collide && pid == 3'b010 && sync_ok && e_data == nbytes)
            check_val({name, "_bc_err"}, bc_err, e_bc);
        check_val({name, "_idle"}, int'(rx_busy), 0);
        $display("pkt %s pid=%0d n=%0d sync=%0d crc=%0d col=%0d done=%0d err=%0d",
                 name, pid, nbytes, sync_ok, crc_ok, collide, n_done - s_done, n_err - s_err);
    endtask

    initial begin
        logic [2:0] rpid;
        int kind, nb;
        bit sok, cok, col;

        idle(3);
        check_val("rst_outputs", out_vec(), 0);
        check_val("rst_count", int'(byte_count), 0);
        rst = 1'b0;
        idle(2);
        check_val("idle_outputs", out_vec(), 0);

        run_packet("hshake", 3'b011, 0, 1'b1, 1'b1, 1'b0);
        run_packet("token", 3'b001, 2, 1'b1, 1'b1, 1'b0);
        run_packet("data66", 3'b010, 66, 1'b1, 1'b1, 1'b0);
        run_packet("data67", 3'b010, 67, 1'b1, 1'b1, 1'b0);
        run_packet("badsync", 3'b010, 3, 1'b0, 1'b1, 1'b0);
        run_packet("token1", 3'b001, 1, 1'b1, 1'b1, 1'b0);
        run_packet("data_col", 3'b010, 5, 1'b1, 1'b1, 1'b1);
        run_packet("data_crcbad", 3'b010, 4, 1'b1, 1'b0, 1'b0);

        // Reset mid-payload must clear everything without waiting for a clock edge.
        sync_status = 2'b01;
        pid_status  = 3'b010;
        start_detect = 1'b1;
        tick();
        start_detect = 1'b0;
        idle(1);
        pulse_byte();
        idle(1);
        pulse_byte();
        idle(2);
        for (int i = 0; i < 10; i++) begin
            pulse_byte();
            idle(1);
        end
        check_val("pre_rst_count", int'(byte_count), 10);
        check_val("pre_rst_load_data", int'(load_data), 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_outputs", out_vec(), 0);
        check_val("midrst_count", int'(byte_count), 0);
        idle(2);
        rst = 1'b0;
        idle(1);
        run_packet("post_rst", 3'b010, 6, 1'b1, 1'b1, 1'b0);

`ifdef RX_BYTE_TIMEOUT_EN
        begin
            int s_tmo, s_err;
            s_tmo = n_tmo;
            s_err = n_err;
            sync_status = 2'b01;
            pid_status  = 3'b010;
            start_detect = 1'b1;
            tick();
            start_detect = 1'b0;
            idle(1);
            pulse_byte();
            idle(1);
            pulse_byte();
            idle(TIMEOUT_CYCLES + 10);
            check_val("tmo_pulse", n_tmo - s_tmo, 1);
            check_val("tmo_err", n_err - s_err, 1);
            check_val("tmo_idle", int'(rx_busy), 0);
        end
`endif

        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(9, 0);
            sok = 1'b1;
            cok = ($urandom_range(4, 0) != 0);
            case (kind)
                0, 1, 2: begin rpid = 3'b010; nb = $urandom_range(12, 0); end
                3, 4:    begin rpid = 3'b001; nb = $urandom_range(4, 0); end
                5:       begin rpid = 3'b011; nb = ($urandom_range(3, 0) == 0) ? 1 : 0; end
                6:       begin rpid = 3'b100; nb = $urandom_range(2, 0); end
                7:       begin rpid = 3'b000; nb = $urandom_range(2, 0); end
                8:       begin rpid = 3'($urandom_range(3, 1)); nb = $urandom_range(3, 0); sok = 1'b0; end
                default: begin rpid = 3'b010; nb = $urandom_range(70, 60); end
            endcase
            col = (nb >= 1) && ($urandom_range(5, 0) == 0);
            run_packet($sformatf("rnd%0d", p), rpid, nb, sok, cok, col);
        end

`ifndef RX_BYTE_TIMEOUT_EN
        check_val("no_timeout", n_tmo, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
